// File: rtl/adder_operand_collector.sv
// adder_operand_collector: ping-pong collector packing a serial operand stream into zero-filled 4-operand groups
module adder_operand_collector #(
  parameter int W = 16,
  parameter int NOPS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [2:0]   out_cnt,
  output logic         err_ovf
);
  if (NOPS != 4) begin : g_bad_nops
    $error("adder_operand_collector supports only NOPS == 4");
  end
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;
  bank_state_t state [2];
  logic [W-1:0] data [2][4];
  logic [2:0] cnt [2];
  logic wr_bank, rd_bank, acc, con, ovf;
  logic [2:0] idx;
  assign in_ready = state[wr_bank] != FULL;
  assign out_valid = state[rd_bank] == FULL;
  assign acc = in_valid & in_ready;
  assign con = out_valid & out_ready;
  assign ovf = idx == 3'd4;
  assign a = out_valid ? data[rd_bank][0] : '0;
  assign b = out_valid ? data[rd_bank][1] : '0;
  assign c = out_valid ? data[rd_bank][2] : '0;
  assign d = out_valid ? data[rd_bank][3] : '0;
  assign out_cnt = out_valid ? cnt[rd_bank] : '0;
  // A bank is written only while not FULL and read only while FULL, so consume and accept never hit the same bank
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= EMPTY;
        cnt[i] <= '0;
        for (int j = 0; j < 4; j++) data[i][j] <= '0;
      end
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      idx <= '0;
      err_ovf <= 1'b0;
    end else begin
      err_ovf <= acc & ovf;
      if (con) begin
        state[rd_bank] <= EMPTY;
        cnt[rd_bank] <= '0;
        for (int j = 0; j < 4; j++) data[rd_bank][j] <= '0;
        rd_bank <= ~rd_bank;
      end
      if (acc) begin
        if (!ovf) begin
          data[wr_bank][idx[1:0]] <= in_data;
          cnt[wr_bank] <= idx + 3'd1;
        end
        state[wr_bank] <= in_last ? FULL : FILLING;
        idx <= in_last ? 3'd0 : ovf ? idx : idx + 3'd1;
        if (in_last) wr_bank <= ~wr_bank;
      end
    end
endmodule

// File: tb/tb_adder_operand_collector.sv
// tb_adder_operand_collector: directed scenario tests for the operand collector
module tb_adder_operand_collector;
  logic clk = 0, rst = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_data = 0;
  logic in_ready, out_valid, err_ovf;
  logic [15:0] a, b, c, d;
  logic [2:0] out_cnt;
  int checks = 0, failures = 0;

  adder_operand_collector #(.W(16), .NOPS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .c(c),
    .d(d), .out_cnt(out_cnt), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [15:0] v, input logic l);
    int n = 0;
    in_valid = 1; in_data = v; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin failures++; $display("FAIL send_timeout data=%h in_ready=%b want 1", v, in_ready); end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic test_reset();
    in_valid = 1; in_data = 16'h55; in_last = 0;
    @(posedge clk); #1;
    in_valid = 0;
    #2 rst = 1; #1;
    checks++;
    if ({in_ready, out_valid, err_ovf, out_cnt, a, b, c, d} !== {1'b1, 1'b0, 1'b0, 3'd0, 64'd0}) begin
      failures++;
      $display("FAIL reset_outputs rdy=%b vld=%b err=%b cnt=%0d abcd=%h %h %h %h want 1 0 0 0 zeros",
               in_ready, out_valid, err_ovf, out_cnt, a, b, c, d);
    end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_group();
    out_ready = 1;
    send(1, 0); send(2, 0); send(3, 0); send(4, 1);
    checks++;
    if ({out_valid, a, b, c, d, out_cnt} !== {1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 3'd4}) begin
      failures++;
      $display("FAIL full_group vld=%b abcd=%h %h %h %h cnt=%0d want 1 0001 0002 0003 0004 4", out_valid, a, b, c, d, out_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL full_group_consumed vld=%b want 0", out_valid); end
  endtask

  task automatic test_partial();
    send(16'h3000, 0); send(16'h4000, 1);
    checks++;
    if ({out_valid, a, b, c, d, out_cnt} !== {1'b1, 16'h3000, 16'h4000, 16'h0, 16'h0, 3'd2}) begin
      failures++;
      $display("FAIL partial vld=%b abcd=%h %h %h %h cnt=%0d want 1 3000 4000 0000 0000 2", out_valid, a, b, c, d, out_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    checks++;
    if (err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_none err=%b want 0", err_ovf); end
    send(5, 0);
    checks++;
    if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_first err=%b want 1", err_ovf); end
    send(6, 1);
    checks++;
    if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_second err=%b want 1", err_ovf); end
    checks++;
    if ({out_valid, a, b, c, d, out_cnt} !== {1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 3'd4}) begin
      failures++;
      $display("FAIL ovf_group vld=%b abcd=%h %h %h %h cnt=%0d want 1 0001 0002 0003 0004 4", out_valid, a, b, c, d, out_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if ({err_ovf, out_valid} !== 2'b00) begin failures++; $display("FAIL ovf_end err=%b vld=%b want 0 0", err_ovf, out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    send(5, 1); send(6, 0); send(7, 1);
    in_valid = 1; in_data = 8; in_last = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall in_ready=%b want 0", in_ready); end
    checks++;
    if ({out_valid, a, b, out_cnt} !== {1'b1, 16'd5, 16'd0, 3'd1}) begin
      failures++;
      $display("FAIL b2b_hold vld=%b a=%h b=%h cnt=%0d want 1 0005 0000 1", out_valid, a, b, out_cnt);
    end
    out_ready = 1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, a, b, c, out_cnt, in_ready} !== {1'b1, 16'd6, 16'd7, 16'd0, 3'd2, 1'b1}) begin
      failures++;
      $display("FAIL b2b_second vld=%b a=%h b=%h c=%h cnt=%0d rdy=%b want 1 0006 0007 0000 2 1", out_valid, a, b, c, out_cnt, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    checks++;
    if ({out_valid, a, b, out_cnt} !== {1'b1, 16'd8, 16'd0, 3'd1}) begin
      failures++;
      $display("FAIL b2b_third vld=%b a=%h b=%h cnt=%0d want 1 0008 0000 1", out_valid, a, b, out_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained vld=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_group();
    send(9, 0); send(10, 0);
    #2 rst = 1; #1;
    checks++;
    if ({in_ready, out_valid, out_cnt, a} !== {1'b1, 1'b0, 3'd0, 16'd0}) begin
      failures++;
      $display("FAIL midrst_outputs rdy=%b vld=%b cnt=%0d a=%h want 1 0 0 0000", in_ready, out_valid, out_cnt, a);
    end
    @(posedge clk); #1 rst = 0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_group vld=%b want 0", out_valid); end
    send(11, 1);
    checks++;
    if ({out_valid, a, b, c, d, out_cnt} !== {1'b1, 16'd11, 16'd0, 16'd0, 16'd0, 3'd1}) begin
      failures++;
      $display("FAIL midrst_next vld=%b abcd=%h %h %h %h cnt=%0d want 1 000b 0000 0000 0000 1", out_valid, a, b, c, d, out_cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_full_group();
    test_partial();
    test_overflow();
    test_back_to_back();
    test_reset_mid_group();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
